// File: rtl/jac1_regval_uart_tx_pkg.sv
// Shared definitions for the JAC1 register-value UART tracer:
// tx FSM state encodings, the idle line level and the default bit period.
package jac1_regval_uart_tx_pkg;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_e;

   localparam logic UART_IDLE_LVL    = 1'b1;
   localparam int   DEF_CLKS_PER_BIT = 16;

   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/jac1_regval_uart_tx_fifo.sv
// Capture FIFO: synchronous reset, first-word fall-through (dout shows the head
// whenever empty=0). A push into a full FIFO is accepted only alongside a pop.
module jac1_sync_fifo
   import jac1_regval_uart_tx_pkg::*;
#(
   parameter int DataWidth  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          sys_res,
   input  logic                          push,
   input  logic                          pop,
   input  logic [DataWidth-1:0]          din,
   output logic [DataWidth-1:0]          dout,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = level_width(FIFO_DEPTH);

   logic [DataWidth-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic                 do_push;
   logic                 do_pop;

   assign full    = (level == LW'(FIFO_DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (sys_res) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage needs no reset; pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/jac1_regval_uart_tx.sv
// Traces JAC1 reg_val changes out as UART frames (8N1, or 8E1 when
// JAC1_TX_PARITY_EN is defined). Holds the change detector, baud counter and tx FSM.
module jac1_regval_uart_tx
   import jac1_regval_uart_tx_pkg::*;
#(
   parameter int DataWidth    = 8,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          sys_res,
   input  logic [DataWidth-1:0]          reg_val,
   input  logic                          cap_en,
   output logic                          tx,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DataWidth - 1);

   // change detector
   logic [DataWidth-1:0] last_val;
   logic                 seen;
   logic                 cap;
   logic                 ovf_q;

   // fifo interface
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [DataWidth-1:0] fifo_dout;

   // tx FSM
   tx_state_e            state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [BW-1:0]        bit_idx, bit_nxt;
   logic [DataWidth-1:0] shreg, sh_nxt;
   logic                 tx_q, tx_nxt;
   logic                 load;
   logic                 bit_end;
`ifdef JAC1_TX_PARITY_EN
   logic                 par, par_nxt;
`endif

   assign cap = cap_en & (~seen | (reg_val != last_val));

   always_ff @(posedge clk) begin
      if (sys_res) begin
         last_val <= '0;
         seen     <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (cap) begin
         // last_val follows even a dropped sample so it is never retried
         last_val <= reg_val;
         seen     <= 1'b1;
         if (fifo_full & ~pop) ovf_q <= 1'b1;
      end
   end

   jac1_sync_fifo #(
      .DataWidth  (DataWidth),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .sys_res (sys_res),
      .push    (cap),
      .pop     (pop),
      .din     (reg_val),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign bit_end = (cnt == '0);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_idx;
      sh_nxt    = shreg;
      tx_nxt    = tx_q;
      load      = 1'b0;
`ifdef JAC1_TX_PARITY_EN
      par_nxt   = par;
`endif
      if (state != TX_IDLE && !bit_end) begin
         cnt_nxt = cnt - 1'b1;
      end else begin
         case (state)
            TX_IDLE: begin
               tx_nxt = UART_IDLE_LVL;
               load   = ~fifo_empty;
            end
            TX_START: begin
               state_nxt = TX_DATA;
               tx_nxt    = shreg[0];
               bit_nxt   = '0;
               cnt_nxt   = CNT_LOAD;
            end
            TX_DATA: begin
               cnt_nxt = CNT_LOAD;
               if (bit_idx == LAST_BIT) begin
`ifdef JAC1_TX_PARITY_EN
                  state_nxt = TX_PARITY;
                  tx_nxt    = par;
`else
                  state_nxt = TX_STOP;
                  tx_nxt    = UART_IDLE_LVL;
`endif
               end else begin
                  bit_nxt = bit_idx + 1'b1;
                  sh_nxt  = shreg >> 1;
                  tx_nxt  = shreg[1];
               end
            end
            TX_PARITY: begin
               state_nxt = TX_STOP;
               tx_nxt    = UART_IDLE_LVL;
               cnt_nxt   = CNT_LOAD;
            end
            TX_STOP: begin
               // chain straight into the next frame when data is waiting
               state_nxt = TX_IDLE;
               tx_nxt    = UART_IDLE_LVL;
               load      = ~fifo_empty;
            end
            default: begin
               state_nxt = TX_IDLE;
               tx_nxt    = UART_IDLE_LVL;
            end
         endcase
      end
      if (load) begin
         state_nxt = TX_START;
         sh_nxt    = fifo_dout;
         tx_nxt    = 1'b0;
         cnt_nxt   = CNT_LOAD;
`ifdef JAC1_TX_PARITY_EN
         par_nxt   = ^fifo_dout;
`endif
      end
   end

   assign pop = load;

   always_ff @(posedge clk) begin
      if (sys_res) begin
         state   <= TX_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx_q    <= UART_IDLE_LVL;
`ifdef JAC1_TX_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_nxt;
         shreg   <= sh_nxt;
         tx_q    <= tx_nxt;
`ifdef JAC1_TX_PARITY_EN
         par     <= par_nxt;
`endif
      end
   end

   assign tx       = tx_q;
   assign overflow = ovf_q;
   assign busy     = (state != TX_IDLE) | (fifo_level != '0);

endmodule
